// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_sync input conditioner.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } dbnc_state_t;

  localparam int DBNC_STABLE_DEFAULT = 4;

endpackage

// File: rtl/debounce_sync_sync_2ff.sv
// Two-flip-flop synchronizer for a single asynchronous bit; resets to 0.
// Shared by other blocks that bring asynchronous inputs into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s;

  // First stage may go metastable; only the second stage is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s  <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s  <= r_s1;
    end
  end

  assign o_q = r_s;

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces one asynchronous input into a clean registered level.
// Define DEBOUNCE_SYNC_EDGE_EN to generate the registered rise/fall pulses.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DBNC_STABLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  logic             w_s;
  dbnc_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_busy;
`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic             r_rise;
  logic             r_fall;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (din),
    .o_q   (w_s)
  );

  // Qualification FSM; busy is registered alongside the state so it equals a decode of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE_LO;
      r_cnt   <= CNT_ZERO;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef DEBOUNCE_SYNC_EDGE_EN
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`endif
    end else begin
`ifdef DEBOUNCE_SYNC_EDGE_EN
      r_rise <= 1'b0;
      r_fall <= 1'b0;
`endif
      case (r_state)
        IDLE_LO: begin
          if (w_s) begin
            r_state <= WAIT_HI;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (!w_s) begin
            r_state <= IDLE_LO;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= IDLE_HI;
            r_cnt   <= CNT_ZERO;
            r_dout  <= 1'b1;
            r_busy  <= 1'b0;
`ifdef DEBOUNCE_SYNC_EDGE_EN
            r_rise  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!w_s) begin
            r_state <= WAIT_LO;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (w_s) begin
            r_state <= IDLE_HI;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= IDLE_LO;
            r_cnt   <= CNT_ZERO;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef DEBOUNCE_SYNC_EDGE_EN
            r_fall  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE_LO;
          r_cnt   <= CNT_ZERO;
          r_dout  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign busy = r_busy;
`ifdef DEBOUNCE_SYNC_EDGE_EN
  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: two instances (STABLE_CYCLES 4 and 1) share din/reset.
// Expected outputs come from a run-length model of the debounce rule.
module tb_debounce_sync;

`ifdef DEBOUNCE_SYNC_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic dout4, rise4, fall4, busy4;
  logic dout1, rise1, fall1, busy1;

  always #5 clk = ~clk;

  debounce_sync #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .din(din),
    .dout(dout4), .rise(rise4), .fall(fall4), .busy(busy4)
  );

  debounce_sync #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .din(din),
    .dout(dout1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [7:0] expq[$];

  // Reference model: dout flips once s has differed from it for N+1 consecutive samples.
  int   n_req [2] = '{4, 1};
  int   run   [2];
  logic mdout [2];
  logic hist  [$];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      run[i]   = 0;
      mdout[i] = 1'b0;
    end
    hist = '{1'b0, 1'b0};
  endtask

  task automatic model_edge(input int i, input logic s, output logic [3:0] e);
    logic r;
    logic f;
    r = 1'b0;
    f = 1'b0;
    if (s != mdout[i]) begin
      run[i]++;
      if (run[i] == n_req[i] + 1) begin
        mdout[i] = s;
        run[i]   = 0;
        r = s & EDGE;
        f = ~s & EDGE;
      end
    end else begin
      run[i] = 0;
    end
    e = {mdout[i], r, f, (run[i] != 0)};
  endtask

  // One clock: model the edge with the din that was present, then apply new reset/din.
  task automatic cycle(input logic d, input logic r);
    logic [3:0] e4;
    logic [3:0] e1;
    logic       s;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      s = hist.pop_front();
      hist.push_back(din);
      model_edge(0, s, e4);
      model_edge(1, s, e1);
    end else begin
      model_clear();
    end
    reset = r;
    if (r) model_clear();
    din = d;
    e4 = {mdout[0], 3'b000} | ((run[0] != 0) ? 4'b0001 : 4'b0000) | (r ? 4'b0000 : e4 & 4'b0110);
    e1 = {mdout[1], 3'b000} | ((run[1] != 0) ? 4'b0001 : 4'b0000) | (r ? 4'b0000 : e1 & 4'b0110);
    expq.push_back({e4, e1});
  endtask

  task automatic seg(input logic d, input int n);
    for (int k = 0; k < n; k++) cycle(d, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard away from the active edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        compared++;
        if ({dout4, rise4, fall4, busy4} !== e[7:4]) begin
          mismatched++;
          $display("FAIL n4_outputs cycle %0d: dout/rise/fall/busy got %b expected %b",
                   cyc, {dout4, rise4, fall4, busy4}, e[7:4]);
        end
        compared++;
        if ({dout1, rise1, fall1, busy1} !== e[3:0]) begin
          mismatched++;
          $display("FAIL n1_outputs cycle %0d: dout/rise/fall/busy got %b expected %b",
                   cyc, {dout1, rise1, fall1, busy1}, e[3:0]);
        end
      end
    end
  end

  initial begin
    int lvl;
    reset = 1'b1;
    din   = 1'b1;
    model_clear();
    // Reset with din high, then full qualification after release.
    seg(1'b1, 0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
    seg(1'b1, 15);
    // Clean fall and rise.
    seg(1'b0, 20);
    seg(1'b1, 20);
    seg(1'b0, 20);
    // Glitch of three cycles, then one cycle.
    seg(1'b1, 3);
    seg(1'b0, 15);
    seg(1'b1, 1);
    seg(1'b0, 15);
    // Reset during qualification, din held high across it.
    seg(1'b1, 4);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    seg(1'b1, 15);
    // Randomized level segments with occasional resets.
    lvl = 0;
    for (int k = 0; k < 300; k++) begin
      lvl = 1 - lvl;
      if ($urandom_range(0, 49) == 0) begin
        cycle(lvl[0], 1'b1);
        seg(lvl[0], 1);
      end else begin
        seg(lvl[0], $urandom_range(1, 8));
      end
    end
    seg(1'b0, 10);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioner placed directly upstream of the team's D flip-flop storage stages. It takes one asynchronous, bouncy input (push-button or external strobe), synchronizes it into the `clk` domain with two flip-flops, and filters it with a counter-based state machine. It presents a clean, registered level plus optional single-cycle edge pulses that downstream registers use directly as `D` or enable inputs.

## Interface
- `STABLE_CYCLES`, default 4: consecutive cycles the synchronized input must hold a new value before `dout` follows; legal range 1..65535.
- `CNT_W`, derived localparam `$clog2(STABLE_CYCLES+1)`: counter width, not overridable.

- `clk`  input  1  clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `din`  input  1  raw asynchronous input; no timing relationship to `clk`.
- `dout`  output  1  debounced, registered level.
- `rise`  output  1  one-cycle pulse when `dout` goes 0→1.
- `fall`  output  1  one-cycle pulse when `dout` goes 1→0.
- `busy`  output  1  high while a candidate transition is being qualified.

## Operation
- Synchronizer: `s1 <= din; s <= s1;`. Only `s` feeds the logic downstream of it.
- FSM states, all registered: `IDLE_LO`, `WAIT_HI`, `IDLE_HI`, `WAIT_LO`.
  - `IDLE_LO`: `dout=0`. If `s==1`, go to `WAIT_HI` with `cnt<=1`.
  - `WAIT_HI`: if `s==0`, go to `IDLE_LO` with `cnt<=0`; the glitch is rejected. Else if `cnt==STABLE_CYCLES`, go to `IDLE_HI` with `dout<=1`, `cnt<=0`. Else `cnt<=cnt+1`.
  - `IDLE_HI` / `WAIT_LO`: mirror of the above with polarity inverted.
- With `STABLE_CYCLES==1`, the WAIT state is entered and exits on the next edge if `s` still holds.
- `cnt` never exceeds `STABLE_CYCLES`; no wrap-around is possible.
- `busy = (state==WAIT_HI) || (state==WAIT_LO)`, decoded from state.
- Edge pulses are registered and asserted in the same cycle that `dout` changes. They deassert on the next edge.
- `rise` and `fall` are mutually exclusive by construction.
- A new transition cannot start until the FSM has returned to an IDLE state. The minimum spacing between `dout` changes is `STABLE_CYCLES+1` cycles.

## Timing
- Reset values: `s1=0`, `s=0`, `state=IDLE_LO`, `cnt=0`, `dout=0`, `rise=0`, `fall=0`, `busy=0`.
- Reset is asynchronous assert. Reset mid-WAIT abandons the qualification with no pulse.
- If `din` is high at reset release, the full qualification runs again before `dout` goes high.
- Latency, with `din` changing and meeting setup before edge 0:
  - `s` changes at edge 2.
  - FSM enters WAIT at edge 3.
  - `dout`, `rise`/`fall` update at edge `3+STABLE_CYCLES`.
  - Default `STABLE_CYCLES=4`: update at edge 7.
- Glitch rejection: any excursion of `s` shorter than `STABLE_CYCLES+1` cycles produces no output change.
- Metastability on `s1` is tolerated. The design intent is a 1-cycle latency uncertainty only.

## Configuration
- Macro `DEBOUNCE_SYNC_EDGE_EN`.
- Defined: `rise` and `fall` are generated as described above.
- Undefined: edge registers are omitted; `rise` and `fall` are tied to constant 0. The port list is unchanged. `dout` and `busy` behaviour is identical.

## Structure
- Shared package `debounce_pkg`:
  - state enum `dbnc_state_t` (`IDLE_LO`, `WAIT_HI`, `IDLE_HI`, `WAIT_LO`).
  - `DBNC_STABLE_DEFAULT = 4`.
- One sub-module, `sync_2ff`: two-flip-flop synchronizer with asynchronous active-high reset to 0. It is reused elsewhere for other asynchronous inputs.
- The FSM, counter and edge logic live in `debounce_sync` itself.

## Test plan
- Reset check: assert `reset` with `din=1` → all outputs 0. After release, `dout` rises at edge 7 (`STABLE_CYCLES=4`) with `rise` high for exactly 1 cycle.
- Clean rise then fall: `din` 0→1 before edge 0 → `dout=1` and `rise=1` at edge 7. Then `din` 1→0 before edge 20 → `dout=0` and `fall=1` at edge 27. `busy` is high on edges 3–6 and 23–26.
- Glitch rejection: `din` high for 3 cycles, then low → `dout` stays 0, no pulses. `busy` rises and then clears.
- Reset mid-qualification: `din` 0→1, assert `reset` at edge 5 → `dout=0`, `busy=0` immediately. With `din` still high, `dout` rises 7 edges after release.
- Boundary `STABLE_CYCLES=1`: `din` 0→1 before edge 0 → `dout=1` at edge 4. A 1-cycle glitch on `s` is rejected.
- Macro undefined: repeat the clean rise/fall scenario → `dout` timing is identical, `rise` and `fall` are constant 0.
